// File: rtl/ring_div_ctrl.sv
// rtl/ring_div_ctrl.sv - ring-oscillator divider tap controller with gated edge counter
// Optional sweep mode (tap_sel..7) is built only when RING_DIV_CTRL_SWEEP_EN is defined.
module ring_div_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int WINDOW_CYCLES = 1024,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             sweep,
  input  logic [2:0]       tap_sel,
  input  logic             ring_in,
  output logic             ring_en,
  output logic [2:0]       div_sel,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;
  localparam logic [1:0] S_REPORT  = 2'd3;

  localparam logic [15:0] LP_SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] LP_WIN_LAST    = 16'(WINDOW_CYCLES - 1);

  logic [1:0]       r_state;
  logic [15:0]      r_timer;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_result;
  logic [2:0]       r_div_sel;
  logic             r_ring_en;
  logic             r_valid;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_sync3;

  logic             w_edge;
  logic             w_start_ok;
  logic             w_sweep_go;
  logic [CNT_W-1:0] w_cnt_next;

  // r_sync3 is the registered copy of the synchronizer output used for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= ring_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_edge     = r_sync2 & ~r_sync3;
  assign w_start_ok = (r_state == S_IDLE) && start && !abort;
  assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, w_edge};

`ifdef RING_DIV_CTRL_SWEEP_EN
  logic r_sweep;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sweep <= 1'b0;
    end else if (w_start_ok) begin
      r_sweep <= sweep;
    end
  end

  assign w_sweep_go = r_sweep && (r_div_sel != 3'd7);
`else
  logic w_unused_sweep;

  assign w_unused_sweep = sweep;
  assign w_sweep_go     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_timer   <= 16'd0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_div_sel <= 3'd0;
      r_ring_en <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if ((r_state != S_IDLE) && abort) begin
        r_state   <= S_IDLE;
        r_ring_en <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start_ok) begin
              r_div_sel <= tap_sel;
              r_ring_en <= 1'b1;
              r_timer   <= 16'd0;
              r_state   <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (r_timer == LP_SETTLE_LAST) begin
              r_timer <= 16'd0;
              r_cnt   <= '0;
              r_state <= S_MEASURE;
            end else begin
              r_timer <= r_timer + 16'd1;
            end
          end
          S_MEASURE: begin
            r_cnt <= w_cnt_next;
            // The edge seen in the last window cycle still belongs to the result
            if (r_timer == LP_WIN_LAST) begin
              r_result <= w_cnt_next;
              r_valid  <= 1'b1;
              r_state  <= S_REPORT;
            end else begin
              r_timer <= r_timer + 16'd1;
            end
          end
          default: begin
            if (w_sweep_go) begin
              r_div_sel <= r_div_sel + 3'd1;
              r_timer   <= 16'd0;
              r_state   <= S_SETTLE;
            end else begin
              r_ring_en <= 1'b0;
              r_state   <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign ring_en      = r_ring_en;
  assign div_sel      = r_div_sel;
  assign result       = r_result;
  assign result_valid = r_valid;
  assign busy         = (r_state != S_IDLE);

endmodule
